round_timer: RTL
================

// Module: round_timer
// PURPOSE
//  Parametrised round timer for the game core, replacing the fixed 4-bit per-clock timer.
//  Divides clk into game ticks with an internal prescaler.
//  Counts a round up (elapsed) or down (remaining), pauses while gameState is low,
//  and pulses cout once when the round expires. Feeds the score/round controller and the display.
// PARAMETERS
//  CNT_W      4           width of roundTime and sum
//  TICK_DIV   50_000_000  clk cycles per game tick (>=1); PRE_W = $clog2(TICK_DIV) (min 1) is a localparam
//  WARN_LEVEL 2           warn asserts when remaining ticks <= WARN_LEVEL
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-low reset
//  gameState  in   1      1 = game running, 0 = paused
//  start      in   1      1-cycle pulse: begin/restart round
//  abort      in   1      1-cycle pulse: cancel round, return to idle
//  countDown  in   1      0 = count up 0->roundTime, 1 = count down roundTime->0; sampled at start
//  roundTime  in   CNT_W  round length in ticks; sampled at start
//  sum        out  CNT_W  current count (elapsed or remaining)
//  cout       out  1      1-cycle expiry pulse
//  busy       out  1      1 in RUN or PAUSE
//  warn       out  1      busy && remaining <= WARN_LEVEL
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; sum=0; cout=0; busy=0; warn=0; prescaler=0; limit/mode regs=0.
//  All outputs registered except warn, which is decoded from registers only (no input paths).
//  States: IDLE, RUN, PAUSE, DONE.
//  Priority in every state: abort > start > pause/tick.
//   abort: ->IDLE, sum=0, prescaler=0, cout=0.
//   start with roundTime!=0: latch limit=roundTime and mode=countDown.
//     Set sum = countDown ? roundTime : 0, prescaler=0, ->RUN; busy=1 after that edge.
//     Restarts cleanly from RUN/PAUSE/DONE. A tick in the same cycle is discarded, with no cout.
//   start with roundTime==0: ignored (no state or output change).
//  RUN: gameState=0 -> PAUSE; prescaler and sum frozen.
//    Otherwise the prescaler counts 0..TICK_DIV-1 and wraps.
//    The cycle with prescaler==TICK_DIV-1 is a tick: sum +1 (up) or -1 (down).
//  Expiry: a tick that makes sum==limit (up) or sum==0 (down).
//    On that same edge: cout=1, busy=0, ->DONE.
//  cout is high for exactly one clk, then 0.
//  PAUSE: gameState=1 -> RUN; prescaler resumes from its held value, so total RUN time per tick is preserved.
//  DONE: sum holds its final value; busy=0; only start/abort leave the state.
//  Latency: first tick occurs TICK_DIV RUN cycles after the start edge.
//    Expiry occurs limit*TICK_DIV RUN cycles after start.
//  TICK_DIV=1: a tick every RUN cycle.
//  remaining = mode ? sum : limit-sum (CNT_W bits, no overflow since sum<=limit).
//  gameState and countDown changes mid-round: only gameState has effect; mode stays latched.
// CONFIGURATION
//  TIMER_AUTORELOAD_EN defined: on expiry the FSM stays in RUN.
//    sum reloads its start value (0 up / limit down) on the expiry edge, cout pulses, and busy stays 1.
//    Rounds repeat back-to-back with period limit*TICK_DIV RUN cycles.
//  Undefined: expiry goes to DONE as above (one-shot).
// TESTING (bench: CNT_W=4, TICK_DIV=2, WARN_LEVEL=2, gameState=1 unless noted)
//  1. Reset: drive reset=0 mid-RUN -> sum=0, cout=0, busy=0, warn=0 immediately.
//     Release -> stays IDLE.
//  2. Count-up: countDown=0, roundTime=5, start.
//     -> sum 1,2,3,4,5 every 2 clk; cout=1 for one clk on edge 10 after start with sum=5.
//     busy falls on that edge. warn high from sum=3.
//  3. Count-down: countDown=1, roundTime=3, start.
//     -> sum 3,2,1,0; warn=1 from sum=2 on; cout on edge 6 with sum=0.
//  4. Pause: roundTime=5 up; gameState=0 for 7 clk after edge 3.
//     -> sum frozen, state PAUSE; cout on edge 17 instead of 10.
//  5. Corners: start with roundTime=0 -> no change.
//     start+abort same cycle -> IDLE, sum=0.
//     start on a tick cycle -> sum reloads, no cout.
//  6. TIMER_AUTORELOAD_EN: roundTime=5 up -> cout on edges 10, 20, 30.
//     sum returns to 0 at each pulse; busy stays 1.
//     Without the macro: single cout, sum holds 5.

Source files
------------

// File: rtl/round_timer.sv
// Round timer: prescaled game ticks, up/down count, pause on gameState low, one-cycle expiry pulse.
// Optional TIMER_AUTORELOAD_EN: expiry reloads the start value and keeps running instead of stopping.
//
// state   | meaning
// S_IDLE  | no round loaded, sum cleared
// S_RUN   | counting, prescaler advancing
// S_PAUSE | round active but frozen (gameState low)
// S_DONE  | round expired, sum holds final value
module round_timer #(
    parameter int CNT_W      = 4,
    parameter int TICK_DIV   = 50_000_000,
    parameter int WARN_LEVEL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gameState,
    input  logic             start,
    input  logic             abort,
    input  logic             countDown,
    input  logic [CNT_W-1:0] roundTime,
    output logic [CNT_W-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             warn
);

    localparam int               PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             mode_q, mode_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] sum_tick;
    logic [CNT_W-1:0] sum_start;
    logic             expire;
    logic [CNT_W-1:0] remaining;

    always_comb begin
        sum_tick  = mode_q ? (sum_q - 1'b1) : (sum_q + 1'b1);
        sum_start = mode_q ? limit_q : '0;
        expire    = mode_q ? (sum_tick == '0) : (sum_tick == limit_q);
    end

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        limit_d = limit_q;
        pre_d   = pre_q;
        mode_d  = mode_q;
        cout_d  = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            sum_d   = '0;
            pre_d   = '0;
        end else if (start && (roundTime != '0)) begin
            // A restart discards any tick that would have landed on this edge.
            state_d = S_RUN;
            limit_d = roundTime;
            mode_d  = countDown;
            sum_d   = countDown ? roundTime : '0;
            pre_d   = '0;
        end else begin
            unique case (state_q)
                S_RUN, S_PAUSE: begin
                    if (!gameState) begin
                        state_d = S_PAUSE;
                    end else begin
                        // Resuming from PAUSE counts on the same edge, so only gameState-low cycles are lost.
                        state_d = S_RUN;
                        if (pre_q == PRE_MAX) begin
                            pre_d = '0;
                            if (expire) begin
                                cout_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                                sum_d  = sum_start;
`else
                                sum_d   = sum_tick;
                                state_d = S_DONE;
`endif
                            end else begin
                                sum_d = sum_tick;
                            end
                        end else begin
                            pre_d = pre_q + 1'b1;
                        end
                    end
                end
                S_IDLE, S_DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            limit_q <= '0;
            pre_q   <= '0;
            mode_q  <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            limit_q <= limit_d;
            pre_q   <= pre_d;
            mode_q  <= mode_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
        end
    end

    // sum never passes limit, so limit - sum cannot wrap.
    always_comb begin
        remaining = mode_q ? sum_q : (limit_q - sum_q);
        warn      = busy_q && (32'(remaining) <= 32'(WARN_LEVEL));
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;

endmodule
